ram_arbiter: RTL

- Shares one single-port, synchronous-read RAM (8192 x 8 default) between two requesters: port A (CPU) and port B (DMA/video fetch).
- Arbitration is round-robin, with an optional bounded lock for bursts.
- Drives the RAM address, write enable and write data combinationally from the granted request.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits directly between the requesters and the RAM instance.

---
 rtl/ram_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous-read RAM between port A (CPU) and port B (DMA/video).
// Latency: zero cycles from request to RAM issue (grant is combinational); read data returns one cycle after the grant.
// Backpressure: a requester holds its request until X_gnt; round-robin arbitration with a bounded lock for bursts.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_write,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_d_in,
  input  logic [DATA_W-1:0] ram_d_out
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED_A = 2'd1,
    LOCKED_B = 2'd2
  } lock_state_e;

  localparam logic       PORT_A     = 1'b0;
  localparam logic       PORT_B     = 1'b1;
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  lock_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_port_q, rsp_port_d;
  logic        keep_lock;
  logic [7:0]  cnt_entry;

  // Grant decision: an active lock wins, else a lone requester, else the port not granted last.
  // Grants are held low while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == LOCKED_A && a_req) begin
        a_gnt = 1'b1;
      end else if (state_q == LOCKED_B && b_req) begin
        b_gnt = 1'b1;
      end else if (a_req && b_req) begin
        if (last_q == PORT_B) a_gnt = 1'b1;
        else                  b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  // RAM drive follows the granted port; port A fields are the idle default, and only a granted write writes.
  always_comb begin
    ram_addr  = a_addr;
    ram_d_in  = a_wdata;
    ram_write = 1'b0;
    if (b_gnt) begin
      ram_addr  = b_addr;
      ram_d_in  = b_wdata;
      ram_write = b_write;
    end else if (a_gnt) begin
      ram_write = a_write;
    end
  end

  // Lock FSM next state and bound counter. The counter tracks contested grants to the lock owner,
  // including the grant that forms the lock, so the owner gets at most LOCK_MAX grants in a row
  // while the other port waits. When the other port is idle the counter holds and the lock is unbounded.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    keep_lock = 1'b0;
    cnt_entry = 8'd0;
    if (state_q == LOCKED_A && a_gnt && a_lock) begin
      keep_lock = 1'b1;
      if (b_req && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      if (cnt_d >= LOCK_MAX_C) keep_lock = 1'b0;
    end else if (state_q == LOCKED_B && b_gnt && b_lock) begin
      keep_lock = 1'b1;
      if (a_req && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      if (cnt_d >= LOCK_MAX_C) keep_lock = 1'b0;
    end
    if (!keep_lock) begin
      state_d = UNLOCKED;
      // A port that just lost its lock may not re-form it in the same cycle.
      if (a_gnt && a_lock && state_q != LOCKED_A) begin
        cnt_entry = b_req ? 8'd1 : 8'd0;
        if (cnt_entry < LOCK_MAX_C) begin
          state_d = LOCKED_A;
          cnt_d   = cnt_entry;
        end
      end else if (b_gnt && b_lock && state_q != LOCKED_B) begin
        cnt_entry = a_req ? 8'd1 : 8'd0;
        if (cnt_entry < LOCK_MAX_C) begin
          state_d = LOCKED_B;
          cnt_d   = cnt_entry;
        end
      end
    end
  end

  // Round-robin pointer and read response tag for the next cycle's returning data.
  always_comb begin
    last_d      = last_q;
    rsp_valid_d = (a_gnt && !a_write) || (b_gnt && !b_write);
    rsp_port_d  = b_gnt ? PORT_B : PORT_A;
    if (a_gnt) last_d = PORT_A;
    if (b_gnt) last_d = PORT_B;
  end

  // Arbiter state registers; last resets to B so A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      cnt_q       <= 8'd0;
      last_q      <= PORT_B;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_A;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
    end
  end

  assign a_rvalid = rsp_valid_q && (rsp_port_q == PORT_A);
  assign b_rvalid = rsp_valid_q && (rsp_port_q == PORT_B);
  assign a_rdata  = ram_d_out;
  assign b_rdata  = ram_d_out;

endmodule
